// File: rtl/sha1_pkg.sv
// Shared constants and FSM state encoding for the SHA-1 message padder.
package sha1_pkg;

  localparam int BLK_W     = 512;
  localparam int BLK_BYTES = 64;
  localparam int LEN_POS   = 56;
  localparam int LEN_BYTES = 8;
  localparam int IDX_W     = $clog2(BLK_BYTES);

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_PAD,
    ST_SEND,
    ST_WAIT,
    ST_EXTRA
  } state_t;

endpackage

// File: rtl/sha1_blk_buf.sv
// 64-byte block register: byte write, pad-at-index (0x80 then zeros),
// full clear, and big-endian insertion of the 64-bit length field.
module sha1_blk_buf
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic               pad_en,
  input  logic               len_en,
  input  logic [IDX_W-1:0]   idx,
  input  logic [7:0]         wr_data,
  input  logic [LEN_W-1:0]   len,
  output logic [BLK_W-1:0]   blk
);

  logic [7:0]             mem [BLK_BYTES];
  logic [8*LEN_BYTES-1:0] len_field;

  // Length field is always 64 bits; narrower counters zero-extend.
  assign len_field = 64'(len);

  always_ff @(posedge clk) begin
    // NOTE: this storage is reset explicitly because the block must read as
    // all zeros right after reset; plain data RAMs normally are not reset.
    if (!rst_n) begin
      for (int i = 0; i < BLK_BYTES; i++) mem[i] <= '0;
    end else begin
      if (clr) begin
        for (int i = 0; i < BLK_BYTES; i++) mem[i] <= '0;
      end else if (wr_en) begin
        mem[idx] <= wr_data;
      end else if (pad_en) begin
        for (int i = 0; i < BLK_BYTES; i++) begin
          if (i == int'(idx))     mem[i] <= PAD_BYTE;
          else if (i > int'(idx)) mem[i] <= '0;
        end
      end
      // Issued last so the length overrides any zeroing in the same cycle.
      if (len_en) begin
        for (int k = 0; k < LEN_BYTES; k++)
          mem[LEN_POS+k] <= len_field[8*(LEN_BYTES-1-k) +: 8];
      end
    end
  end

  always_comb begin
    blk = '0;
    for (int i = 0; i < BLK_BYTES; i++) blk[BLK_W-1-8*i -: 8] = mem[i];
  end

endmodule

// File: rtl/sha1_pad.sv
// SHA-1 message padder: collects bytes into 512-bit blocks, appends 0x80,
// zero fill and the bit length, and hands blocks to the core via START/DONE.
module sha1_pad
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [7:0]       DIN,
  input  logic             DIN_VALID,
  input  logic             DIN_LAST,
  output logic             DIN_READY,
  output logic             START,
  output logic [BLK_W-1:0] SHA1IN,
  output logic             FIRST_BLK,
  output logic             LAST_BLK,
  input  logic             DONE,
  output logic             BUSY
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;         // length-only block still owed
  logic             pad_pend_q, pad_pend_d; // full data block sent, pad owed

  logic buf_clr, buf_wr, buf_pad, buf_len;

  sha1_blk_buf #(.LEN_W(LEN_W)) u_buf (
    .clk     (CLK),
    .rst_n   (nRST),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .pad_en  (buf_pad),
    .len_en  (buf_len),
    .idx     (cnt_q),
    .wr_data (DIN),
    .len     (len_q),
    .blk     (SHA1IN)
  );

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!nRST) begin
      state_q    <= ST_COLLECT;
      cnt_q      <= '0;
      len_q      <= '0;
      first_q    <= 1'b1;
      last_q     <= 1'b0;
      pend_q     <= 1'b0;
      pad_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      first_q    <= first_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      pad_pend_q <= pad_pend_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    first_d    = first_q;
    last_d     = last_q;
    pend_d     = pend_q;
    pad_pend_d = pad_pend_q;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    buf_pad    = 1'b0;
    buf_len    = 1'b0;
    DIN_READY  = 1'b0;
    START      = 1'b0;

    unique case (state_q)
      ST_COLLECT: begin
        DIN_READY = 1'b1;
        if (DIN_VALID) begin
          buf_wr = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          len_d  = len_q + LEN_W'(8);
          // A full block ships first; a final 64th byte pads a fresh block.
          if (cnt_q == IDX_W'(BLK_BYTES - 1)) begin
            state_d    = ST_SEND;
            pad_pend_d = DIN_LAST;
          end else if (DIN_LAST) begin
            state_d = ST_PAD;
          end
        end
      end

      ST_PAD: begin
        buf_pad    = 1'b1;
        pad_pend_d = 1'b0;
        cnt_d      = '0;
        if (cnt_q <= IDX_W'(LEN_POS - 1)) begin
          buf_len = 1'b1;
          last_d  = 1'b1;
        end else begin
          pend_d = 1'b1;
        end
        state_d = ST_SEND;
      end

      ST_SEND: begin
        START   = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (DONE) begin
          first_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            first_d = 1'b1;
            len_d   = '0;
          end
          if (pend_q)          state_d = ST_EXTRA;
          else if (pad_pend_q) state_d = ST_PAD;
          else                 state_d = ST_COLLECT;
        end
      end

      ST_EXTRA: begin
        buf_clr = 1'b1;
        buf_len = 1'b1;
        last_d  = 1'b1;
        pend_d  = 1'b0;
        state_d = ST_SEND;
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  assign FIRST_BLK = first_q;
  assign LAST_BLK  = last_q;
  assign BUSY      = !((state_q == ST_COLLECT) && (cnt_q == '0));

endmodule

// File: doc/sha1_pad.md
SHA1_PAD -- requirements
Module: sha1_pad

Interface
- REQ-001 Parameter: LEN_W, default 64, width of the message bit-length counter and of the appended length field.
- REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
- REQ-003 nRST  input  1  synchronous, active-low reset.
- REQ-004 DIN  input  8  message byte.
- REQ-005 DIN_VALID  input  1  DIN valid.
- REQ-006 DIN_LAST  input  1  qualifies DIN as final byte of message.
- REQ-007 DIN_READY  output  1  byte accepted when DIN_VALID & DIN_READY.
- REQ-008 START  output  1  one-cycle pulse to SHA-1 core: block on SHA1IN is ready.
- REQ-009 SHA1IN  output  512  padded block, big-endian, first byte in [511:504].
- REQ-010 FIRST_BLK  output  1  block is first of message; core loads IV.
- REQ-011 LAST_BLK  output  1  block is final of message; core result is the digest.
- REQ-012 DONE  input  1  core finished current block.
- REQ-013 BUSY  output  1  high in any state other than COLLECT with byte count 0.

Function
- REQ-014 States: COLLECT, PAD, SEND, WAIT, EXTRA.
- REQ-015 COLLECT: DIN_READY=1; each accepted byte is written at position cnt (0..63), cnt increments and the bit-length counter adds 8, modulo 2^LEN_W.
- REQ-016 An accepted 64th byte without DIN_LAST -> SEND, cnt wraps to 0.
- REQ-017 An accepted byte with DIN_LAST -> PAD; DIN_READY=0 in every state except COLLECT.
- REQ-018 PAD (one cycle): byte 0x80 is placed at position p=cnt (p=0 in a fresh block if the last byte filled position 63) and the remaining bytes are zeroed; if p<=55, the length is written to bytes 56..63 and LAST_BLK is set; else a second block is flagged pending. Next state: SEND.
- REQ-019 SEND (one cycle): START=1; SHA1IN, FIRST_BLK and LAST_BLK are stable from this cycle until DONE is sampled. Next state: WAIT.
- REQ-020 WAIT: DONE=1 -> EXTRA if a second block is pending; else COLLECT. FIRST_BLK clears after any block is sent. After a LAST_BLK block, the length counter clears and FIRST_BLK sets for the next message.
- REQ-021 EXTRA (one cycle): the block becomes all zeros plus the length in bytes 56..63, LAST_BLK=1, next state SEND.
- REQ-022 DONE outside WAIT is ignored; START is never asserted in the same cycle that DONE is acted on.
- REQ-023 Empty messages are unsupported; DIN_LAST is only meaningful with DIN_VALID.

Reset
- REQ-024 While nRST=0 at an edge: state=COLLECT, cnt=0, length=0, buffer=0, START=0, LAST_BLK=0, FIRST_BLK=1, pending flag=0; DIN_READY=1 from the first cycle after release.
- REQ-025 Reset mid-message or mid-WAIT discards the partial message; a late DONE from the core after reset is ignored.

Structure
- REQ-026 Shared package sha1_pkg: state enum, BLK_W=512, BLK_BYTES=64, LEN_POS=56, PAD_BYTE=8'h80.
- REQ-027 One sub-module, sha1_blk_buf: a 64-byte byte-addressable register with clear, byte write, and length insert.

Verification
- REQ-028 "abc" (last on 0x63) -> one START, SHA1IN=61626380 00..00 00000000_00000018, FIRST_BLK=LAST_BLK=1.
- REQ-029 55 bytes -> one block, 0x80 at byte 55, length 0x1B8.
- REQ-030 56 bytes -> two STARTs; block 2 all zero except length 0x1C0, FIRST_BLK=0 and LAST_BLK=1 on block 2.
- REQ-031 64 bytes -> block 1 is the raw data with LAST_BLK=0; block 2 is 0x80 at byte 0 with length 0x200.
- REQ-032 DONE delayed 100 cycles -> DIN_READY=0 and SHA1IN constant throughout; two back-to-back messages both show FIRST_BLK on their first block.
- REQ-033 nRST pulsed during WAIT, followed by a stray DONE -> no START, state COLLECT, next "abc" produces the REQ-028 block.
